// File: rtl/game_flow_controller.sv
// Game flow sequencer: start, lives/respawn, level progression, score divider, win/game-over and restart.
// Define GAME_FLOW_BOOST_EN to build the lava speed-boost pulse generator; otherwise speed_boost_pulse is tied low.
module game_flow_controller #(
    parameter int SCORE_DIV   = 6,
    parameter int BOOST_STEP  = 50,
    parameter int START_LIVES = 3,
    parameter int HOLD_TICKS  = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic        any_input_level,
    input  logic        restart_btn,
    input  logic        hit_lava_wall,
    input  logic        hit_hazard,
    input  logic        reached_goal,
    output logic        freeze,
    output logic        speed_boost_pulse,
    output logic [1:0]  level,
    output logic [1:0]  lives,
    output logic [11:0] score,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PLAY        = 3'd1,
        S_RESPAWN     = 3'd2,
        S_LEVEL_CLEAR = 3'd3,
        S_WIN         = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(SCORE_DIV - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
    localparam logic [11:0] SCORE_MAX  = 12'hFFF;

    if (SCORE_DIV < 1 || SCORE_DIV > 255) begin : g_bad_score_div
        $error("SCORE_DIV out of range 1..255");
    end
    if (BOOST_STEP < 1 || BOOST_STEP > 4095) begin : g_bad_boost_step
        $error("BOOST_STEP out of range 1..4095");
    end
    if (START_LIVES < 1 || START_LIVES > 3) begin : g_bad_start_lives
        $error("START_LIVES out of range 1..3");
    end
    if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold_ticks
        $error("HOLD_TICKS out of range 1..255");
    end

    state_t     state_q;
    logic [7:0] div_cnt;
    logic [7:0] hold_cnt;
    logic       hit;
    logic       score_step;
    logic       restart_go;

    assign hit        = hit_lava_wall | hit_hazard;
    assign score_step = (state_q == S_PLAY) && (div_cnt == DIV_LAST) && (score != SCORE_MAX);
    assign restart_go = ((state_q == S_WIN) || (state_q == S_GAME_OVER)) && restart_btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            level    <= 2'd0;
            lives    <= LIVES_INIT;
            score    <= 12'd0;
            div_cnt  <= 8'd0;
            hold_cnt <= 8'd0;
        end else if (game_tick) begin
            // Divider and score run on every PLAY tick, including the tick that leaves PLAY.
            if (state_q == S_PLAY) begin
                div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
                if (score_step) begin
                    score <= score + 12'd1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (any_input_level) begin
                        state_q <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        if (lives <= 2'd1) begin
                            lives   <= 2'd0;
                            state_q <= S_GAME_OVER;
                        end else begin
                            lives    <= lives - 2'd1;
                            hold_cnt <= 8'd0;
                            state_q  <= S_RESPAWN;
                        end
                    end else if (reached_goal) begin
                        if (level == 2'd2) begin
                            state_q <= S_WIN;
                        end else begin
                            hold_cnt <= 8'd0;
                            state_q  <= S_LEVEL_CLEAR;
                        end
                    end
                end
                S_RESPAWN, S_LEVEL_CLEAR: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_q <= S_PLAY;
                        if (state_q == S_LEVEL_CLEAR) begin
                            level <= level + 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_WIN, S_GAME_OVER: begin
                    if (restart_go) begin
                        state_q <= S_IDLE;
                        score   <= 12'd0;
                        level   <= 2'd0;
                        lives   <= LIVES_INIT;
                        div_cnt <= 8'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state  = state_q;
    assign freeze = (state_q == S_RESPAWN) || (state_q == S_LEVEL_CLEAR) ||
                    (state_q == S_WIN) || (state_q == S_GAME_OVER);

`ifdef GAME_FLOW_BOOST_EN
    localparam logic [11:0] BOOST_LAST = 12'(BOOST_STEP - 1);

    // boost_cnt tracks score modulo BOOST_STEP, avoiding a divider on the score bus.
    logic [11:0] boost_cnt;
    logic        pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boost_cnt <= 12'd0;
            pulse_q   <= 1'b0;
        end else if (game_tick) begin
            pulse_q <= 1'b0;
            if (restart_go) begin
                boost_cnt <= 12'd0;
            end else if (score_step) begin
                if (boost_cnt == BOOST_LAST) begin
                    boost_cnt <= 12'd0;
                    pulse_q   <= 1'b1;
                end else begin
                    boost_cnt <= boost_cnt + 12'd1;
                end
            end
        end
    end

    assign speed_boost_pulse = pulse_q;
`else
    assign speed_boost_pulse = 1'b0;
`endif

endmodule
